// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - control/handshake bundle between the sequence generator and its consumer
interface sequence_generator_if #(
  parameter int SEQ_INDEX_BITS = 4
);
  logic                      start;
  logic                      halt;
  logic                      available;
  logic                      ready;
  logic                      first;
  logic                      finished;
  logic [SEQ_INDEX_BITS-1:0] seq_index;
  logic [SEQ_INDEX_BITS-1:0] seq_top;
  logic [4:0]                seq_gate;

  modport master (
    input  start, halt, available,
    output ready, first, finished, seq_index, seq_top, seq_gate
  );

  modport slave (
    output start, halt, available,
    input  ready, first, finished, seq_index, seq_top, seq_gate
  );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - odometer enumerator of gate sequences, presented most-significant digit first
module sequence_generator #(
  parameter int SEQ_INDEX_BITS    = 4,
  parameter int HIGHEST_SEQ_INDEX = 9,
  parameter int HIGHEST_GATE      = 15
) (
  input logic                 clk,
  input logic                 reset,
  sequence_generator_if.master bus
);
  localparam int NUM_DIGITS = HIGHEST_SEQ_INDEX + 1;
  localparam logic [4:0] MAX_GATE = 5'(HIGHEST_GATE);
  localparam logic [SEQ_INDEX_BITS-1:0] MAX_TOP = SEQ_INDEX_BITS'(HIGHEST_SEQ_INDEX);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EMIT     = 2'd1;
  localparam logic [1:0] ADVANCE  = 2'd2;
  localparam logic [1:0] FINISHED = 2'd3;

  logic [1:0]                state;
  logic [4:0]                digit     [NUM_DIGITS];
  logic [4:0]                inc_digit [NUM_DIGITS];
  logic                      carry;
  logic [SEQ_INDEX_BITS-1:0] k_idx;
  logic [4:0]                k_gate;
  logic [4:0]                down_gate;
  logic                      start_ok;

  // One-cycle odometer increment over the active digits; k is the highest digit that moved.
  always_comb begin
    carry  = 1'b1;
    k_idx  = '0;
    k_gate = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc_digit[i] = digit[i];
      if (carry && (i <= int'(bus.seq_top))) begin
        if (digit[i] == MAX_GATE) begin
          inc_digit[i] = '0;
        end else begin
          inc_digit[i] = digit[i] + 5'd1;
          carry        = 1'b0;
          k_idx        = SEQ_INDEX_BITS'(i);
          k_gate       = digit[i] + 5'd1;
        end
      end
    end
  end

  // Digit that becomes visible after a transfer at seq_index > 0.
  always_comb begin
    down_gate = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (SEQ_INDEX_BITS'(i) + 1'b1 == bus.seq_index) begin
        down_gate = digit[i];
      end
    end
  end

  assign start_ok = bus.start &&
                    ((state == IDLE) || ((state == FINISHED) && !bus.halt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.ready     <= 1'b0;
      bus.first     <= 1'b0;
      bus.finished  <= 1'b0;
      bus.seq_index <= '0;
      bus.seq_gate  <= '0;
      bus.seq_top   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else if (start_ok) begin
      state         <= EMIT;
      bus.ready     <= 1'b1;
      bus.first     <= 1'b1;
      bus.finished  <= 1'b0;
      bus.seq_index <= '0;
      bus.seq_gate  <= '0;
      bus.seq_top   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else if (bus.halt && (state != IDLE)) begin
      state        <= FINISHED;
      bus.ready    <= 1'b0;
      bus.finished <= 1'b1;
    end else begin
      case (state)
        EMIT: begin
          if (bus.available) begin
            if (bus.seq_index != '0) begin
              bus.seq_index <= bus.seq_index - 1'b1;
              bus.seq_gate  <= down_gate;
              bus.first     <= 1'b0;
            end else begin
              state     <= ADVANCE;
              bus.ready <= 1'b0;
            end
          end
        end
        ADVANCE: begin
          if (!carry) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= inc_digit[i];
            state         <= EMIT;
            bus.ready     <= 1'b1;
            bus.seq_index <= k_idx;
            bus.seq_gate  <= k_gate;
            bus.first     <= (k_idx == bus.seq_top);
          end else if (bus.seq_top < MAX_TOP) begin
            // Odometer rolled over: grow by one digit and restart from all zeros.
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
            state         <= EMIT;
            bus.ready     <= 1'b1;
            bus.seq_top   <= bus.seq_top + 1'b1;
            bus.seq_index <= bus.seq_top + 1'b1;
            bus.seq_gate  <= '0;
            bus.first     <= 1'b1;
          end else begin
            state        <= FINISHED;
            bus.finished <= 1'b1;
          end
        end
        IDLE, FINISHED: begin
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - scoreboard bench for sequence_generator with a base-arithmetic reference list
module tb_sequence_generator;
  localparam int SIB = 2;
  localparam int HSI = 1;
  localparam int HG  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_generator_if #(.SEQ_INDEX_BITS(SIB)) bus ();

  sequence_generator #(
    .SEQ_INDEX_BITS(SIB),
    .HIGHEST_SEQ_INDEX(HSI),
    .HIGHEST_GATE(HG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int idx;
    int gate;
    int first;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int xfer_count = 0;
  int cycle = 0;
  bit gap_mode = 0;
  bit stable_mode = 0;
  bit have_last = 0;
  int last_cycle, last_idx;
  bit prev_hold = 0;
  int held_idx, held_gate, held_first, held_top;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int digit_of(input int v, input int pos);
    int r = v;
    for (int j = 0; j < pos; j++) r = r / (HG + 1);
    return r % (HG + 1);
  endfunction

  // Reference: all values of each length in counting order; after the first value
  // only digits up to the highest one that differs from the previous value are shown.
  task automatic push_expected(input int limit);
    int pushed = 0;
    item_t it;
    for (int len = 1; len <= HSI + 1; len++) begin
      int total = 1;
      for (int j = 0; j < len; j++) total = total * (HG + 1);
      for (int v = 0; v < total; v++) begin
        int top = len - 1;
        if (v != 0) begin
          top = 0;
          for (int j = 0; j < len; j++)
            if (digit_of(v, j) != digit_of(v - 1, j)) top = j;
        end
        for (int i = top; i >= 0; i--) begin
          it.idx = i;
          it.gate = digit_of(v, i);
          it.first = (i == len - 1) ? 1 : 0;
          if (pushed < limit) exp_q.push_back(it);
          pushed++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      if (stable_mode && prev_hold && bus.ready) begin
        check("hold_index", int'(bus.seq_index), held_idx);
        check("hold_gate", int'(bus.seq_gate), held_gate);
        check("hold_first", int'(bus.first), held_first);
        check("hold_top", int'(bus.seq_top), held_top);
      end
      if (bus.ready) check("gate_range", int'(bus.seq_gate <= 5'(HG)), 1);
      if (bus.ready && bus.available) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", int'(bus.seq_index), -1);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("xfer_index", int'(bus.seq_index), e.idx);
          check("xfer_gate", int'(bus.seq_gate), e.gate);
          check("xfer_first", int'(bus.first), e.first);
          check("xfer_top_ge_index", int'(bus.seq_top >= bus.seq_index), 1);
        end
        if (gap_mode && have_last)
          check("xfer_gap", cycle - last_cycle, (last_idx == 0) ? 2 : 1);
        have_last  = 1;
        last_cycle = cycle;
        last_idx   = int'(bus.seq_index);
        xfer_count++;
      end
      prev_hold  = bus.ready && !bus.available;
      held_idx   = int'(bus.seq_index);
      held_gate  = int'(bus.seq_gate);
      held_first = int'(bus.first);
      held_top   = int'(bus.seq_top);
    end else begin
      prev_hold = 0;
      have_last = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    have_last = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // mode 0: available held high, 1: pattern 1,0,0,1, 2: random
  task automatic run_to_finish(input int mode, input bit rand_start);
    int k = 0;
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (bus.finished) begin
        done = 1;
      end else begin
        case (mode)
          0: bus.available = 1'b1;
          1: bus.available = (k % 4 == 0 || k % 4 == 3);
          default: bus.available = 1'($urandom_range(0, 1));
        endcase
        k++;
        bus.start = rand_start && bus.ready && ($urandom_range(0, 3) == 0);
        tick();
        bus.start = 1'b0;
      end
    end
    check("finish_timeout", int'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(bus.ready), 0);
    check({tag, "_first"}, int'(bus.first), 0);
    check({tag, "_finished"}, int'(bus.finished), 0);
    check({tag, "_index"}, int'(bus.seq_index), 0);
    check({tag, "_gate"}, int'(bus.seq_gate), 0);
    check({tag, "_top"}, int'(bus.seq_top), 0);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.available = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("idle_halt_ready", int'(bus.ready), 0);
    check("idle_halt_finished", int'(bus.finished), 0);

    // Full list, available held high, exact bubble timing
    gap_mode = 1;
    bus.available = 1'b1;
    push_expected(1000);
    pulse_start();
    check("start_ready", int'(bus.ready), 1);
    run_to_finish(0, 0);
    gap_mode = 0;
    check("runA_finished", int'(bus.finished), 1);
    check("runA_ready", int'(bus.ready), 0);
    check("runA_queue", exp_q.size(), 0);

    // Restart from FINISHED with toggling availability and start pokes during EMIT
    stable_mode = 1;
    bus.available = 1'b1;
    push_expected(1000);
    pulse_start();
    check("restart_ready", int'(bus.ready), 1);
    check("restart_index", int'(bus.seq_index), 0);
    check("restart_gate", int'(bus.seq_gate), 0);
    check("restart_first", int'(bus.first), 1);
    check("restart_finished", int'(bus.finished), 0);
    run_to_finish(1, 1);
    check("runB_queue", exp_q.size(), 0);

    bus.start = 1'b1;
    bus.halt = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.halt = 1'b0;
    check("start_halt_finished", int'(bus.finished), 1);
    check("start_halt_ready", int'(bus.ready), 0);

    push_expected(1000);
    pulse_start();
    run_to_finish(2, 1);
    check("runC_queue", exp_q.size(), 0);
    stable_mode = 0;

    // Halt coinciding with the fourth transfer
    bus.available = 1'b1;
    base = xfer_count;
    push_expected(4);
    pulse_start();
    for (int c = 0; c < 50 && !(bus.ready && xfer_count == base + 3); c++) tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    repeat (3) tick();
    check("halt_xfers", xfer_count - base, 4);
    check("halt_finished", int'(bus.finished), 1);
    check("halt_ready", int'(bus.ready), 0);
    check("halt_queue", exp_q.size(), 0);

    // Reset while the fifth item is presented
    base = xfer_count;
    push_expected(1000);
    pulse_start();
    for (int c = 0; c < 50 && !(bus.ready && xfer_count == base + 4); c++) tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_xfers", xfer_count - base, 4);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_reset_idle_ready", int'(bus.ready), 0);
    push_expected(1000);
    pulse_start();
    run_to_finish(0, 0);
    check("runD_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL take parameter SEQ_INDEX_BITS, default 4: width of seq_index and seq_top.
REQ-002 SHALL take parameter HIGHEST_SEQ_INDEX, default 9: maximum sequence index, so maximum length is HIGHEST_SEQ_INDEX+1.
REQ-003 SHALL take parameter HIGHEST_GATE, default 15: highest gate code; valid codes are 0..HIGHEST_GATE, with HIGHEST_GATE<=30.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin enumeration.
REQ-007 SHALL have port halt  input  1  stop request, e.g. from the solution checker.
REQ-008 SHALL have port seq_index  output  SEQ_INDEX_BITS  index of the presented gate.
REQ-009 SHALL have port seq_gate  output  5  gate code at seq_index.
REQ-010 SHALL have port first  output  1  high when seq_index equals seq_top.
REQ-011 SHALL have port ready  output  1  presented item is valid.
REQ-012 SHALL have port available  input  1  consumer can accept an item.
REQ-013 SHALL have port seq_top  output  SEQ_INDEX_BITS  current sequence length minus 1.
REQ-014 SHALL have port finished  output  1  enumeration complete or halted.

Function
REQ-015 SHALL enumerate every gate sequence, ordered by increasing length L = 1..HIGHEST_SEQ_INDEX+1, using an odometer of digits d[0..L-1]; d[0] is the least significant digit.
REQ-016 SHALL register all outputs.
REQ-017 SHALL use states IDLE, EMIT, ADVANCE and FINISHED.
REQ-018 IDLE: on start, set L=1 and all digits to 0, and enter EMIT with seq_index=0; ready rises on the cycle after start.
REQ-019 EMIT: ready=1, seq_gate=d[seq_index], first=(seq_index==seq_top).
REQ-020 A transfer SHALL occur on any rising edge where ready and available are both high; outputs SHALL be held stable until then.
REQ-021 On a transfer with seq_index>0, seq_index SHALL decrement by 1 and ready SHALL stay high, giving zero bubbles.
REQ-022 On a transfer with seq_index==0, the block SHALL enter ADVANCE with ready=0 for exactly one cycle.
REQ-023 ADVANCE: increment the odometer by 1 with carry; k = highest digit that changed.
REQ-024 ADVANCE, no carry out of d[L-1]: enter EMIT with seq_index=k and first=(k==L-1); only indices k..0 are re-emitted.
REQ-025 ADVANCE, carry out of d[L-1] with L<=HIGHEST_SEQ_INDEX: increment L, zero all digits, and enter EMIT with seq_index=L-1 (new) and first=1.
REQ-026 ADVANCE, carry out of d[L-1] with L==HIGHEST_SEQ_INDEX+1: enter FINISHED.
REQ-027 halt SHALL move any state other than IDLE to FINISHED at the next edge; ready=0 from then on.
REQ-028 If halt coincides with a transfer, the transfer SHALL still count as accepted.
REQ-029 FINISHED: finished=1 and ready=0; start SHALL restart from REQ-018 and clear finished on the same edge.
REQ-030 start SHALL be ignored in EMIT and ADVANCE.
REQ-031 halt in IDLE SHALL be ignored.
REQ-032 If start and halt are high together in FINISHED, halt SHALL win and the block SHALL remain in FINISHED.
REQ-033 seq_top SHALL equal L-1 at all times after start.
REQ-034 seq_gate SHALL never exceed HIGHEST_GATE.

Reset
REQ-035 While reset is low: state=IDLE, ready=0, first=0, finished=0, seq_index=0, seq_gate=0, seq_top=0, L=1, digits=0.
REQ-036 Reset asserted mid-sequence SHALL abort immediately without completing any transfer; after release the block SHALL wait for start.

Verification (HIGHEST_SEQ_INDEX=1, HIGHEST_GATE=1)
REQ-037 With available held 1 and start pulsed, the bench SHALL see transfers (index,gate,first): (0,0,1) (0,1,1) (1,0,1) (0,0,0) (0,1,0) (1,1,1) (0,0,0) (0,1,0), then finished=1.
REQ-038 The bench SHALL confirm exactly one ready-low cycle after each index-0 transfer and none between index 1 and index 0.
REQ-039 With available toggling 1,0,0,1 per cycle, the bench SHALL see the same transfer list and stable outputs while available=0.
REQ-040 halt pulsed during the 4th transfer's cycle -> the bench SHALL see exactly 4 transfers, then finished=1 and ready=0.
REQ-041 reset pulled low during the 5th presented item -> all outputs at reset values; a later start -> the list restarts from (0,0,1).
REQ-042 start in FINISHED -> ready=1 next cycle with (0,0,1) and finished=0; start during EMIT -> no change to the presented item.
